// File: rtl/nrisc_pkg.sv
// nrisc_pkg: shared constants for the nRISC multicycle controller.
//   Opcode encodings (IR[7:5]), ULA operation codes, PC source codes and the
//   controller state enum, plus a helper that flags the states that wait on
//   the memory-ready handshake.
package nrisc_pkg;

    localparam logic [2:0] OP_HALT    = 3'b000;
    localparam logic [2:0] OP_R_ARITH = 3'b001;
    localparam logic [2:0] OP_MEM     = 3'b010;
    localparam logic [2:0] OP_JUMP    = 3'b011;
    localparam logic [2:0] OP_IMM     = 3'b100;
    localparam logic [2:0] OP_R_LOGIC = 3'b101;
    localparam logic [2:0] OP_BEQ     = 3'b110;
    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    localparam logic [1:0] ULA_ARITH    = 2'b00;
    localparam logic [1:0] ULA_SLT_NOT  = 2'b01;
    localparam logic [1:0] ULA_PASS_IMM = 2'b10;
    localparam logic [1:0] ULA_ADD      = 2'b11;

    localparam logic [1:0] PC_ULA    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR, S_MEM_RD,
        S_MEM_WR, S_WB_ULA, S_WB_MEM, S_BRANCH, S_JUMP, S_HALTED
    } state_t;

    function automatic logic is_mem_state(state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/controle_multiciclo_if.sv
// controle_multiciclo_if: bundle between the sequencer and the nRISC datapath.
//   master (controller): takes start/opcode/funct/zero/mem_ready, drives all
//   datapath enables, status and counters. slave (datapath side): the reverse.
interface controle_multiciclo_if #(parameter int CNT_W = 16);
    logic             start;
    logic [2:0]       opcode;
    logic             funct;
    logic             zero;
    logic             mem_ready;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             ior_d;
    logic             ir_write;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             ula_src;
    logic [1:0]       ula_op;
    logic             ula_sub;
    logic             halted;
    logic             fault;
    logic [CNT_W-1:0] instr_count;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        input  start, opcode, funct, zero, mem_ready,
        output pc_write, pc_src, ior_d, ir_write, mem_read, mem_write,
               reg_write, reg_dst, mem_to_reg, ula_src, ula_op, ula_sub,
               halted, fault, instr_count, cycle_count
    );

    modport slave (
        output start, opcode, funct, zero, mem_ready,
        input  pc_write, pc_src, ior_d, ir_write, mem_read, mem_write,
               reg_write, reg_dst, mem_to_reg, ula_src, ula_op, ula_sub,
               halted, fault, instr_count, cycle_count
    );
endinterface

// File: rtl/ctrl_mem_watchdog.sv
// ctrl_mem_watchdog: counts cycles spent waiting for mem_ready.
//   Ports: clk, rst_n; waiting (in a memory state), mem_ready, leave (the FSM
//   changes state this cycle); timeout = this is the MEM_TIMEOUT-th waiting
//   cycle and memory still has not answered.
module ctrl_mem_watchdog #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic waiting,
    input  logic mem_ready,
    input  logic leave,
    output logic timeout
);
    localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

    logic [7:0] wait_cnt;

    // wait_cnt holds the number of earlier unanswered cycles in this state,
    // so the compare against MEM_TIMEOUT-1 fires on the MEM_TIMEOUT-th one.
    // mem_ready in that same cycle suppresses it.
    assign timeout = waiting && !mem_ready && (wait_cnt == LAST_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (leave || !waiting) begin
            wait_cnt <= '0;
        end else if (!mem_ready) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end
endmodule

// File: rtl/controle_multiciclo.sv
// controle_multiciclo: multicycle sequencer for the nRISC core.
//   Ports: clk, rst_n (async, active low), bus (master side of
//   controle_multiciclo_if: IR fields, zero flag, memory handshake in;
//   datapath enables, halted/fault, retired-instruction and cycle counters out).
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   IDLE     | waiting for start
//   FETCH    | read memory at PC into IR, PC <= PC+1
//   DECODE   | ULA computes branch target, dispatch on opcode
//   EXEC_R   | register-register ULA operation
//   EXEC_I   | pass immediate through ULA
//   ADDR     | effective address = reg + imm
//   MEM_RD   | load access
//   MEM_WR   | store access (retires on mem_ready)
//   WB_ULA   | write ULA-out to register file (retire)
//   WB_MEM   | write memory data to register file (retire)
//   BRANCH   | BEQ compare, PC <= target if zero (retire)
//   JUMP     | PC <= jump target (retire)
//   HALTED   | stopped by HALT, illegal opcode or memory timeout
module controle_multiciclo
    import nrisc_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    controle_multiciclo_if.master bus
);
    state_t           state, state_nxt;
    logic             fault_q, fault_set, retire, timeout;
    logic [CNT_W-1:0] instr_count, cycle_count;
    logic             pc_write, ior_d, ir_write, mem_read, mem_write;
    logic             reg_write, reg_dst, mem_to_reg, ula_src, ula_sub, halted;
    logic [1:0]       pc_src, ula_op;

    ctrl_mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .waiting   (is_mem_state(state)),
        .mem_ready (bus.mem_ready),
        .leave     (state_nxt != state),
        .timeout   (timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            fault_q     <= 1'b0;
            instr_count <= '0;
            cycle_count <= '0;
        end else begin
            state <= state_nxt;
            if (fault_set) fault_q <= 1'b1;
            if (retire) instr_count <= instr_count + 1'b1;
            if (state != S_IDLE && state != S_HALTED) cycle_count <= cycle_count + 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        fault_set  = 1'b0;
        retire     = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_ULA;
        ior_d      = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        ula_src    = 1'b0;
        ula_op     = ULA_ARITH;
        ula_sub    = 1'b0;
        halted     = 1'b0;
        case (state)
            S_IDLE: if (bus.start) state_nxt = S_FETCH;
            S_FETCH: begin
                mem_read = 1'b1;
                ula_op   = ULA_ADD;
                if (bus.mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    state_nxt = S_DECODE;
                end else if (timeout) begin
                    fault_set = 1'b1;
                    state_nxt = S_HALTED;
                end
            end
            S_DECODE: begin
                ula_op  = ULA_ADD;
                ula_src = 1'b1;
                case (bus.opcode)
                    OP_R_ARITH, OP_R_LOGIC: state_nxt = S_EXEC_R;
                    OP_IMM:                 state_nxt = S_EXEC_I;
                    OP_MEM:                 state_nxt = S_ADDR;
                    OP_BEQ:                 state_nxt = S_BRANCH;
                    OP_JUMP:                state_nxt = S_JUMP;
                    OP_HALT: begin
                        retire    = 1'b1;
                        state_nxt = S_HALTED;
                    end
                    default: begin
                        fault_set = 1'b1;
                        state_nxt = S_HALTED;
                    end
                endcase
            end
            S_EXEC_R: begin
                ula_op    = (bus.opcode == OP_R_LOGIC) ? ULA_SLT_NOT : ULA_ARITH;
                state_nxt = S_WB_ULA;
            end
            S_EXEC_I: begin
                ula_src   = 1'b1;
                ula_op    = ULA_PASS_IMM;
                state_nxt = S_WB_ULA;
            end
            S_ADDR: begin
                ula_src   = 1'b1;
                ula_op    = ULA_ADD;
                state_nxt = bus.funct ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                ior_d    = 1'b1;
                if (bus.mem_ready) begin
                    state_nxt = S_WB_MEM;
                end else if (timeout) begin
                    fault_set = 1'b1;
                    state_nxt = S_HALTED;
                end
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                ior_d     = 1'b1;
                if (bus.mem_ready) begin
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end else if (timeout) begin
                    fault_set = 1'b1;
                    state_nxt = S_HALTED;
                end
            end
            S_WB_ULA: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_BRANCH: begin
                ula_sub   = 1'b1;
                pc_src    = PC_BRANCH;
                pc_write  = bus.zero;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_JUMP: begin
                pc_src    = PC_JUMP;
                pc_write  = 1'b1;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_HALTED: halted = 1'b1;
            default:  state_nxt = S_IDLE;
        endcase
    end

    assign bus.pc_write    = pc_write;
    assign bus.pc_src      = pc_src;
    assign bus.ior_d       = ior_d;
    assign bus.ir_write    = ir_write;
    assign bus.mem_read    = mem_read;
    assign bus.mem_write   = mem_write;
    assign bus.reg_write   = reg_write;
    assign bus.reg_dst     = reg_dst;
    assign bus.mem_to_reg  = mem_to_reg;
    assign bus.ula_src     = ula_src;
    assign bus.ula_op      = ula_op;
    assign bus.ula_sub     = ula_sub;
    assign bus.halted      = halted;
    assign bus.fault       = fault_q;
    assign bus.instr_count = instr_count;
    assign bus.cycle_count = cycle_count;
endmodule

// File: tb/tb_controle_multiciclo.sv
module tb_controle_multiciclo;
    localparam int CNT_W       = 16;
    localparam int MEM_TIMEOUT = 15;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ior_d, ir_write, mem_read, mem_write;
        logic       reg_write, reg_dst, mem_to_reg, ula_src;
        logic [1:0] ula_op;
        logic       ula_sub, halted, fault;
    } ctl_t;

    typedef struct packed {
        logic       start;
        logic [2:0] op;
        logic       funct, zero, ready;
    } stim_t;

    typedef struct packed {
        ctl_t             c;
        logic [CNT_W-1:0] ic, cc;
    } exp_t;

    typedef struct packed {
        stim_t s;
        exp_t  e;
    } plan_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    controle_multiciclo_if #(.CNT_W(CNT_W)) bus ();
    controle_multiciclo #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    plan_t            plan_q[$];
    exp_t             sb_q[$];
    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] m_ic, m_cc;
    logic [2:0]       cur_op;
    logic             cur_funct, cur_zero;

    function automatic ctl_t actual_ctl();
        ctl_t a;
        a.pc_write = bus.pc_write;   a.pc_src = bus.pc_src;     a.ior_d = bus.ior_d;
        a.ir_write = bus.ir_write;   a.mem_read = bus.mem_read; a.mem_write = bus.mem_write;
        a.reg_write = bus.reg_write; a.reg_dst = bus.reg_dst;   a.mem_to_reg = bus.mem_to_reg;
        a.ula_src = bus.ula_src;     a.ula_op = bus.ula_op;     a.ula_sub = bus.ula_sub;
        a.halted = bus.halted;       a.fault = bus.fault;
        return a;
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Scoreboard monitor: one expected record per issued stimulus cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_val("ctl", 32'(actual_ctl()), 32'(e.c));
                check_val("instr_count", 32'(bus.instr_count), 32'(e.ic));
                check_val("cycle_count", 32'(bus.cycle_count), 32'(e.cc));
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not end, got running expected finished");
        $fatal(1);
    end

    // ---------------- reference model: instruction-level expansion ----------------
    task automatic push(input logic rdy, input logic st, input ctl_t c, input bit counts, input bit retire);
        plan_t p;
        p.s = '{st, cur_op, cur_funct, cur_zero, rdy};
        p.e.c = c; p.e.ic = m_ic; p.e.cc = m_cc;
        plan_q.push_back(p);
        if (counts) m_cc = m_cc + 1'b1;
        if (retire) m_ic = m_ic + 1'b1;
    endtask

    task automatic halt_tail(input logic f);
        ctl_t c;
        for (int i = 0; i < 3; i++) begin
            c = '0; c.halted = 1'b1; c.fault = f;
            push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), c, 1'b0, 1'b0);
        end
    endtask

    // kind 0 fetch, 1 load, 2 store; delay = unanswered cycles before ready.
    // res: 0 completed, 1 timed out, 2 cut short after 'limit' cycles.
    task automatic mem_phase(input int kind, input int delay, input int limit, output int res);
        ctl_t c;
        logic rdy;
        res = 0;
        for (int k = 0; k < 1000; k++) begin
            rdy = (k == delay);
            c = '0;
            case (kind)
                0: begin
                    c.mem_read = 1'b1; c.ula_op = 2'b11;
                    if (rdy) begin c.ir_write = 1'b1; c.pc_write = 1'b1; end
                end
                1: begin c.mem_read = 1'b1; c.ior_d = 1'b1; end
                default: begin c.mem_write = 1'b1; c.ior_d = 1'b1; end
            endcase
            push(rdy, 1'b0, c, 1'b1, (kind == 2) && rdy);
            if (rdy) return;
            if (k + 1 == MEM_TIMEOUT) begin res = 1; return; end
            if (k + 1 == limit) begin res = 2; return; end
        end
    endtask

    task automatic do_instr(input logic [2:0] op, input logic funct, input logic zero,
                            input int fd, input int md, input int limit);
        ctl_t c;
        int r;
        cur_op = op; cur_funct = funct; cur_zero = zero;
        mem_phase(0, fd, 0, r);
        if (r == 1) begin halt_tail(1'b1); return; end
        c = '0; c.ula_op = 2'b11; c.ula_src = 1'b1;
        push(1'($urandom_range(0, 1)), 1'b0, c, 1'b1, op == 3'b000);
        case (op)
            3'b000: halt_tail(1'b0);
            3'b111: halt_tail(1'b1);
            3'b001, 3'b101, 3'b100: begin
                c = '0;
                if (op == 3'b100) begin c.ula_src = 1'b1; c.ula_op = 2'b10; end
                else c.ula_op = (op == 3'b101) ? 2'b01 : 2'b00;
                push(1'($urandom_range(0, 1)), 1'b0, c, 1'b1, 1'b0);
                c = '0; c.reg_write = 1'b1; c.reg_dst = 1'b1;
                push(1'($urandom_range(0, 1)), 1'b0, c, 1'b1, 1'b1);
            end
            3'b010: begin
                c = '0; c.ula_src = 1'b1; c.ula_op = 2'b11;
                push(1'($urandom_range(0, 1)), 1'b0, c, 1'b1, 1'b0);
                mem_phase(funct ? 2 : 1, md, limit, r);
                if (r == 1) halt_tail(1'b1);
                else if (r == 0 && !funct) begin
                    c = '0; c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
                    push(1'($urandom_range(0, 1)), 1'b0, c, 1'b1, 1'b1);
                end
            end
            3'b110: begin
                c = '0; c.ula_sub = 1'b1; c.pc_src = 2'b01; c.pc_write = zero;
                push(1'($urandom_range(0, 1)), 1'b0, c, 1'b1, 1'b1);
            end
            default: begin
                c = '0; c.pc_src = 2'b10; c.pc_write = 1'b1;
                push(1'($urandom_range(0, 1)), 1'b0, c, 1'b1, 1'b1);
            end
        endcase
    endtask

    // ---------------- driver ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; bus.start = 1'b0; bus.opcode = '0;
        bus.funct = 1'b0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_ctl", 32'(actual_ctl()), 32'(0));
        check_val("reset_instr_count", 32'(bus.instr_count), 32'(0));
        check_val("reset_cycle_count", 32'(bus.cycle_count), 32'(0));
        rst_n = 1'b1;
    endtask

    task automatic drive(input bit rst_mid);
        plan_t p;
        while (plan_q.size() > 0) begin
            p = plan_q.pop_front();
            @(posedge clk); #1;
            bus.start = p.s.start; bus.opcode = p.s.op; bus.funct = p.s.funct;
            bus.zero = p.s.zero;   bus.mem_ready = p.s.ready;
            sb_q.push_back(p.e);
        end
        @(negedge clk); #1;
        check_val("scoreboard_drained", 32'(sb_q.size()), 32'(0));
        if (rst_mid) begin
            check_val("mem_write_before_reset", 32'(bus.mem_write), 32'(1));
            rst_n = 1'b0;
            #1;
            check_val("mem_write_at_reset", 32'(bus.mem_write), 32'(0));
            check_val("ctl_at_reset", 32'(actual_ctl()), 32'(0));
            check_val("instr_count_at_reset", 32'(bus.instr_count), 32'(0));
            check_val("cycle_count_at_reset", 32'(bus.cycle_count), 32'(0));
        end
    endtask

    // ending: 0 HALT, 1 illegal opcode, 2 fetch timeout, 3 load timeout, 4 reset mid-store
    task automatic episode(input int n, input int ending, input bit directed);
        logic [2:0] legal [6];
        ctl_t c;
        legal[0] = 3'b001; legal[1] = 3'b101; legal[2] = 3'b100;
        legal[3] = 3'b010; legal[4] = 3'b110; legal[5] = 3'b011;
        do_reset();
        m_ic = '0; m_cc = '0;
        cur_op = 3'(($urandom_range(0, 7))); cur_funct = 1'b0; cur_zero = 1'b0;
        c = '0;
        push(1'b0, 1'b0, c, 1'b0, 1'b0);
        push(1'b1, 1'b1, c, 1'b0, 1'b0);
        if (directed) begin
            do_instr(3'b001, 1'b0, 1'b0, 0, 0, 0);
            do_instr(3'b010, 1'b0, 1'b0, 0, 3, 0);
            do_instr(3'b110, 1'b0, 1'b1, 0, 0, 0);
            do_instr(3'b110, 1'b0, 1'b0, 0, 0, 0);
        end
        for (int i = 0; i < n; i++)
            do_instr(legal[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 4), 0);
        case (ending)
            0: do_instr(3'b000, 1'b0, 1'b0, $urandom_range(0, 3), 0, 0);
            1: do_instr(3'b111, 1'b0, 1'b0, $urandom_range(0, 3), 0, 0);
            2: do_instr(legal[$urandom_range(0, 5)], 1'b0, 1'b0, 99, 0, 0);
            3: do_instr(3'b010, 1'b0, 1'b0, 0, 99, 0);
            default: do_instr(3'b010, 1'b1, 1'b0, $urandom_range(0, 3), 99, 3);
        endcase
        drive(ending == 4);
    endtask

    initial begin
        bus.start = 1'b0; bus.opcode = '0; bus.funct = 1'b0;
        bus.zero = 1'b0; bus.mem_ready = 1'b0;
        episode(0, 0, 1'b1);
        episode(0, 2, 1'b0);
        episode(0, 1, 1'b0);
        episode(2, 4, 1'b0);
        episode(3, 3, 1'b0);
        for (int e = 0; e < 8; e++)
            episode($urandom_range(3, 12), $urandom_range(0, 4), 1'b0);
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
